pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_skid_stage.sv | 158 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid stage: state encoding and occupancy constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_of(input state_t s);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    case (s)
      ONE:     occ = OCC_ONE;
      FULL:    occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload+control holding register; clearing zeroes only the control field
// so a discarded entry can never issue side effects downstream.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_ctrl <= '0;
    end else if (i_clr) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_data <= i_data;
      r_ctrl <= i_ctrl;
    end
  end

  assign o_data = r_data;
  assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with fully registered in_ready.
// Optional stall-cycle counter enabled by macro PIPE_SKID_PERF_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [1:0]        r_occ;

  state_t            w_next;
  logic              w_accept;
  logic              w_retire;
  logic              w_main_load;
  logic              w_main_clr;
  logic              w_main_sel_skid;
  logic              w_skid_load;
  logic              w_skid_clr;
  logic [DATA_W-1:0] w_main_d;
  logic [CTRL_W-1:0] w_main_c;
  logic [DATA_W-1:0] w_main_q;
  logic [CTRL_W-1:0] w_main_qc;
  logic [DATA_W-1:0] w_skid_q;
  logic [CTRL_W-1:0] w_skid_qc;

  assign w_accept = in_valid && r_in_ready;
  assign w_retire = r_out_valid && out_ready;

  // Main slot is cleared when it drains to EMPTY so out_ctrl is zero whenever out_valid is low.
  always_comb begin
    w_next          = r_state;
    w_main_load     = 1'b0;
    w_main_clr      = flush;
    w_main_sel_skid = 1'b0;
    w_skid_load     = 1'b0;
    w_skid_clr      = flush;
    if (flush) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_main_load = 1'b1;
            w_next      = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_retire) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load = 1'b1;
            w_next      = FULL;
          end else if (w_retire) begin
            w_main_clr  = 1'b1;
            w_next      = EMPTY;
          end
        end
        FULL: begin
          if (w_retire) begin
            w_main_load     = 1'b1;
            w_main_sel_skid = 1'b1;
            w_next          = ONE;
          end
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q  : in_data;
  assign w_main_c = w_main_sel_skid ? w_skid_qc : in_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= OCC_EMPTY;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next != FULL);
      r_out_valid <= (w_next != EMPTY);
      r_occ       <= occ_of(w_next);
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_main_load),
    .i_clr  (w_main_clr),
    .i_data (w_main_d),
    .i_ctrl (w_main_c),
    .o_data (w_main_q),
    .o_ctrl (w_main_qc)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_load),
    .i_clr  (w_skid_clr),
    .i_data (in_data),
    .i_ctrl (in_ctrl),
    .o_data (w_skid_q),
    .o_ctrl (w_skid_qc)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign out_ctrl  = w_main_qc;
  assign occupancy = r_occ;

`ifdef PIPE_SKID_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating; flush deliberately leaves it alone so stalls across flushes are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed vector table, hand sequences and
// randomized traffic against a queue model. Stall counter checks need PIPE_SKID_PERF_EN.
module tb_pipe_skid_stage;

  localparam int          NW        = 4;
  localparam int unsigned STALL_MAX = (1 << NW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;
`ifdef PIPE_SKID_PERF_EN
  logic [NW-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .DATA_W (32),
    .CTRL_W (8),
    .CNT_W  (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of at most two held entries.
  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } ent_t;

  ent_t        q[$];
  int unsigned m_stall;

  task automatic model_edge();
    int unsigned n;
    n = q.size();
    if (n > 0 && !out_ready && m_stall < STALL_MAX) m_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back('{d: in_data, c: in_ctrl});
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, (q.size() < 2)});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (q.size() > 0)});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, q.size());
    chk({tag, ".out_ctrl"},  {24'd0, out_ctrl},  (q.size() > 0) ? {24'd0, q[0].c} : 32'd0);
    if (q.size() > 0) chk({tag, ".out_data"}, out_data, q[0].d);
`ifdef PIPE_SKID_PERF_EN
    chk({tag, ".stall_cnt"}, {28'd0, stall_cnt}, m_stall);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".out_data"},  out_data,           32'd0);
    chk({tag, ".out_ctrl"},  {24'd0, out_ctrl},  32'd0);
    chk({tag, ".occupancy"}, {30'd0, occupancy}, 32'd0);
`ifdef PIPE_SKID_PERF_EN
    chk({tag, ".stall_cnt"}, {28'd0, stall_cnt}, 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    q.delete();
    m_stall   = 0;
    @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] d;
    logic [7:0]  c;
    logic        ev;
    logic        er;
    logic [1:0]  eo;
    logic [31:0] ed;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // iv ordy fl  data    ctrl  | valid ready occ  data    ctrl
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'hA, 8'h11, 1'b1, 1'b1, 2'd1, 32'hA, 8'h11};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'hB, 8'h22, 1'b1, 1'b0, 2'd2, 32'hA, 8'h11};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'hC, 8'h77, 1'b1, 1'b0, 2'd2, 32'hA, 8'h11};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 2'd1, 32'hB, 8'h22};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 2'd0, 32'h0, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h1, 8'h33, 1'b1, 1'b1, 2'd1, 32'h1, 8'h33};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h2, 8'h44, 1'b1, 1'b1, 2'd1, 32'h2, 8'h44};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h3, 8'h55, 1'b1, 1'b0, 2'd2, 32'h2, 8'h44};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'h4, 8'h66, 1'b0, 1'b1, 2'd0, 32'h0, 8'h00};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 2'd0, 32'h0, 8'h00};

    do_reset();

`ifdef PIPE_SKID_PERF_EN
    in_valid  = 1'b1;
    in_data   = 32'h55;
    in_ctrl   = 8'h5A;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("stall_after_flush", {28'd0, stall_cnt}, 32'd15);
    chk("stall_flush_occ", {30'd0, occupancy}, 32'd0);
    do_reset();
`endif

    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      in_data   = tbl[i].d;
      in_ctrl   = tbl[i].c;
      tick();
      chk($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d.in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].er});
      chk($sformatf("vec%0d.occupancy", i), {30'd0, occupancy}, {30'd0, tbl[i].eo});
      chk($sformatf("vec%0d.out_ctrl", i),  {24'd0, out_ctrl},  {24'd0, tbl[i].ec});
      if (tbl[i].ev) chk($sformatf("vec%0d.out_data", i), out_data, tbl[i].ed);
    end
    flush = 1'b0;
    chk_model("post_tbl");

    // Streaming at full rate with out_ready held high.
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 32'h100 + 32'(i);
      in_ctrl   = 8'(i + 1);
      tick();
      chk($sformatf("stream%0d.out_data", i),  out_data, 32'h100 + 32'(i));
      chk($sformatf("stream%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d.in_ready", i),  {31'd0, in_ready},  32'd1);
      chk($sformatf("stream%0d.occupancy", i), {30'd0, occupancy}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_model("stream_drain");

    // Asynchronous reset between edges while FULL.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'hAA;
    in_ctrl   = 8'hA1;
    tick();
    in_data = 32'hBB;
    in_ctrl = 8'hB2;
    tick();
    chk("areset_pre.occupancy", {30'd0, occupancy}, 32'd2);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("areset");
    q.delete();
    m_stall = 0;
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hCC;
    in_ctrl  = 8'hC3;
    tick();
    chk("areset_first.out_data", out_data, 32'hCC);
    chk_model("areset_first");

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = $urandom;
      in_ctrl   = 8'($urandom);
      tick();
      chk_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
